// File: rtl/pulse_measure_ctrl.sv
// pulse_measure_ctrl: sequencer for one pulse propagation time measurement.
// Launches a transmit pulse, counts cycles until the echo arrives or the
// timeout expires, then holds the count until the consumer acknowledges it.
module pulse_measure_ctrl #(
  parameter int CNT_W     = 16,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 50000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Echo,
  input  logic             i_Ack,
  output logic             o_Tx_Pulse,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic             o_Timeout,
  output logic [CNT_W-1:0] o_Result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value in the last transmit cycle and in the last waiting cycle
  localparam logic [CNT_W-1:0] LAST_FIRE = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] count;

  // Measurement sequencer with registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      count      <= '0;
      o_Tx_Pulse <= 1'b0;
      o_Busy     <= 1'b0;
      o_Valid    <= 1'b0;
      o_Timeout  <= 1'b0;
      o_Result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            state      <= FIRE;
            count      <= '0;
            o_Tx_Pulse <= 1'b1;
            o_Busy     <= 1'b1;
          end
        end
        FIRE, WAIT: begin
          // Echo has priority over the timeout on the final counted edge
          if (i_Echo) begin
            state      <= DONE;
            o_Result   <= count;
            o_Timeout  <= 1'b0;
            o_Tx_Pulse <= 1'b0;
            o_Valid    <= 1'b1;
          end else if (count == LAST_CNT) begin
            state      <= DONE;
            o_Result   <= TO_VAL;
            o_Timeout  <= 1'b1;
            o_Tx_Pulse <= 1'b0;
            o_Valid    <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
            if (state == FIRE && count == LAST_FIRE) begin
              state      <= WAIT;
              o_Tx_Pulse <= 1'b0;
            end
          end
        end
        DONE: begin
          if (i_Ack) begin
            state   <= IDLE;
            o_Valid <= 1'b0;
            o_Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_measure_ctrl.sv
// Bench for pulse_measure_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-offset based reference model.
module tb_pulse_measure_ctrl;

  localparam int CNT_W     = 16;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             echo = 1'b0;
  logic             ack = 1'b0;
  logic             o_Tx_Pulse, o_Busy, o_Valid, o_Timeout;
  logic [CNT_W-1:0] o_Result;

  int checks = 0;
  int errors = 0;
  int tx_cycles = 0;

  pulse_measure_ctrl #(
    .CNT_W    (CNT_W),
    .PULSE_LEN(PULSE_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Start   (start),
    .i_Echo    (echo),
    .i_Ack     (ack),
    .o_Tx_Pulse(o_Tx_Pulse),
    .o_Busy    (o_Busy),
    .o_Valid   (o_Valid),
    .o_Timeout (o_Timeout),
    .o_Result  (o_Result)
  );

  always #5 clk = ~clk;

  // Reference model: a measurement is "in flight" with m_t cycles elapsed
  // since launch, or "held" awaiting acknowledge.
  bit          m_flight = 0;
  bit          m_held   = 0;
  int          m_t      = 0;
  int          m_res    = 0;
  bit          m_to     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flight = 0; m_held = 0; m_t = 0; m_res = 0; m_to = 0;
    end else if (m_held) begin
      if (ack) m_held = 0;
    end else if (m_flight) begin
      if (echo) begin
        m_res = m_t; m_to = 0; m_flight = 0; m_held = 1;
      end else if (m_t + 1 >= TIMEOUT) begin
        m_res = TIMEOUT; m_to = 1; m_flight = 0; m_held = 1;
      end else begin
        m_t = m_t + 1;
      end
    end else if (start) begin
      m_flight = 1; m_t = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("tx",      32'(o_Tx_Pulse), 32'(m_flight && m_t < PULSE_LEN));
      chk("busy",    32'(o_Busy),     32'(m_flight || m_held));
      chk("valid",   32'(o_Valid),    32'(m_held));
      chk("timeout", 32'(o_Timeout),  32'(m_to));
      chk("result",  32'(o_Result),   32'(m_res));
      if (o_Tx_Pulse) tx_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // n < 0: no echo. Returns once o_Valid is seen or the budget runs out.
  task automatic measure(input int n);
    tx_cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n >= 0) begin
      repeat (n) tick();
      echo = 1'b1;
      tick();
      echo = 1'b0;
    end
    for (int i = 0; i < TIMEOUT + 10 && !o_Valid; i++) tick();
    chk("valid_reached", 32'(o_Valid), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx"},     32'(o_Tx_Pulse), 32'd0);
    chk({tag, "_busy"},   32'(o_Busy),     32'd0);
    chk({tag, "_valid"},  32'(o_Valid),    32'd0);
    chk({tag, "_to"},     32'(o_Timeout),  32'd0);
    chk({tag, "_result"}, 32'(o_Result),   32'd0);
  endtask

  initial begin
    #3;
    check_reset_outputs("por");
    tick();
    rst = 1'b0;
    tick();

    // Echo at counter 37
    measure(37);
    chk("m37_result", 32'(o_Result), 32'd37);
    chk("m37_to",     32'(o_Timeout), 32'd0);
    chk("m37_txlen",  32'(tx_cycles), 32'd4);
    chk("m37_busy_held", 32'(o_Busy), 32'd1);
    do_ack();
    chk("m37_busy_after_ack", 32'(o_Busy), 32'd0);

    // Echo inside the transmit pulse
    tick();
    measure(2);
    chk("m2_result", 32'(o_Result), 32'd2);
    chk("m2_txlen",  32'(tx_cycles), 32'd3);
    do_ack();

    // Minimum loop: echo in first FIRE cycle
    tick();
    measure(0);
    chk("m0_result", 32'(o_Result), 32'd0);
    chk("m0_txlen",  32'(tx_cycles), 32'd1);
    do_ack();

    // No echo: timeout
    tick();
    measure(-1);
    chk("to_result", 32'(o_Result), 32'd100);
    chk("to_flag",   32'(o_Timeout), 32'd1);
    chk("to_txlen",  32'(tx_cycles), 32'd4);
    do_ack();

    // Echo on the final counted edge wins over the timeout
    tick();
    measure(99);
    chk("m99_result", 32'(o_Result), 32'd99);
    chk("m99_to",     32'(o_Timeout), 32'd0);

    // Echoes in DONE and IDLE are ignored
    echo = 1'b1; tick(); echo = 1'b0; tick();
    chk("done_echo_result", 32'(o_Result), 32'd99);
    do_ack();
    echo = 1'b1; tick(); tick(); echo = 1'b0; tick();
    chk("idle_echo_busy",   32'(o_Busy),   32'd0);
    chk("idle_echo_result", 32'(o_Result), 32'd99);

    // Start together with ack is dropped
    measure(5);
    tx_cycles = 0;
    start = 1'b1; ack = 1'b1; tick(); start = 1'b0; ack = 1'b0;
    repeat (3) tick();
    chk("start_ack_busy", 32'(o_Busy),    32'd0);
    chk("start_ack_tx",   32'(tx_cycles), 32'd0);
    measure(12);
    chk("m12_result", 32'(o_Result), 32'd12);
    do_ack();

    // Asynchronous reset mid-cycle during FIRE
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_fire");
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-cycle during WAIT
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    tick();
    rst = 1'b0;
    tick();

    measure(10);
    chk("m10_result", 32'(o_Result), 32'd10);
    chk("m10_txlen",  32'(tx_cycles), 32'd4);
    do_ack();

    // Random traffic: frequent echoes, then sparse echoes to reach timeouts
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 2500; c++) begin
        start = ($urandom_range(0, 7) == 0);
        echo  = (phase == 0) ? ($urandom_range(0, 29) == 0)
                             : ($urandom_range(0, 249) == 0);
        ack   = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    start = 1'b0; echo = 1'b0; ack = 1'b0;

    // Drain: let any in-flight measurement finish, then acknowledge it
    for (int i = 0; i < TIMEOUT + 20 && o_Busy; i++) begin
      ack = o_Valid;
      tick();
      ack = 1'b0;
    end
    chk("drain_idle", 32'(o_Busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
